// File: rtl/rtype_instr_encoder_if.sv
// rtl/rtype_instr_encoder_if.sv - request/response bundle for the R-type instruction encoder
// The master drives encode requests and consumes words; the slave is the encoder.
interface rtype_instr_encoder_if #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             illegal;
    logic [ERR_W-1:0] err_count;
    logic [CW-1:0]    fifo_count;

    modport master (
        output in_valid, alu_op, rs1, rs2, rd, out_ready,
        input  in_ready, out_valid, instr, illegal, err_count, fifo_count
    );

    modport slave (
        input  in_valid, alu_op, rs1, rs2, rd, out_ready,
        output in_ready, out_valid, instr, illegal, err_count, fifo_count
    );
endinterface

// File: rtl/rtype_instr_encoder.sv
// rtl/rtype_instr_encoder.sv - RV32 R-type encoder with output FIFO and illegal-op counter
// Legal requests are encoded and queued; illegal ones are dropped and counted.
module rtype_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rtype_instr_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    L_DEPTH   = CW'(DEPTH);
    localparam logic [6:0]       L_OPCODE  = 7'b0110011;
    localparam logic [ERR_W-1:0] L_ERR_MAX = {ERR_W{1'b1}};

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_illegal;
    logic [ERR_W-1:0] r_err_count;

    logic [6:0]       w_fun7;
    logic [2:0]       w_fun3;
    logic             w_legal;
    logic [31:0]      w_word;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    // Operation decode: three legal groups, everything else is illegal.
    always_comb begin
        w_fun7  = 7'b0000000;
        w_fun3  = bus.alu_op[2:0];
        w_legal = 1'b0;
        case (bus.alu_op[4:3])
            2'b00: begin
                w_fun7  = 7'b0000000;
                w_legal = 1'b1;
            end
            2'b10: begin
                if (bus.alu_op[2:0] == 3'b000 || bus.alu_op[2:0] == 3'b101) begin
                    w_fun7  = 7'b0100000;
                    w_legal = 1'b1;
                end
            end
            2'b11: begin
                if (bus.alu_op[2:0] != 3'b110) begin
                    w_fun7  = 7'b0111011;
                    w_legal = 1'b1;
                end
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_word = {w_fun7, bus.rs2, bus.rs1, w_fun3, bus.rd, L_OPCODE};

    // Ready is gated by reset so it reads low while reset is held.
    assign w_in_ready  = i_rst_n && (r_count < L_DEPTH);
    assign w_out_valid = (r_count != '0);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_push      = w_accept && w_legal;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_illegal   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && !w_legal && r_err_count != L_ERR_MAX) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.instr      = w_out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign bus.illegal    = r_illegal;
    assign bus.err_count  = r_err_count;
    assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb/tb_rtype_instr_encoder.sv - directed self-checking bench for rtype_instr_encoder
module tb_rtype_instr_encoder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rtype_instr_encoder_if #(.DEPTH(4), .ERR_W(8)) bus ();

    rtype_instr_encoder #(.DEPTH(4), .ERR_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request for a single edge; returns just after that edge.
    task automatic send(input logic [4:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.rs1      = s1;
        bus.rs2      = s2;
        bus.rd       = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_q [5];
    logic [4:0]  tbl_op [4];
    logic [4:0]  tbl_s1 [4];
    logic [4:0]  tbl_s2 [4];
    logic [4:0]  tbl_rd [4];
    logic [31:0] tbl_w  [4];
    logic        acc;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.out_ready = 1'b0;

        exp_q = '{32'h002081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3};
        tbl_op = '{5'b00111, 5'b10101, 5'b11111, 5'b11101};
        tbl_s1 = '{5'd10, 5'd31, 5'd0, 5'd2};
        tbl_s2 = '{5'd11, 5'd31, 5'd0, 5'd3};
        tbl_rd = '{5'd12, 5'd31, 5'd1, 5'd4};
        tbl_w  = '{32'h00B57633, 32'h41FFDFB3, 32'h760070B3, 32'h76315233};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD x3, x1, x2
        bus.out_ready = 1'b1;
        send(5'b00000, 5'd1, 5'd2, 5'd3);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_instr", bus.instr, 32'h002081B3);
        tick();
        check("add_popped_valid", 32'(bus.out_valid), 32'd0);
        check("add_popped_instr", bus.instr, 32'h0);

        // SUB then 0111011 group; second push coincides with first pop
        send(5'b10000, 5'd5, 5'd6, 5'd7);
        check("sub_instr", bus.instr, 32'h406283B3);
        send(5'b11000, 5'd1, 5'd2, 5'd3);
        check("grp3_instr", bus.instr, 32'h762081B3);
        check("push_pop_count", 32'(bus.fifo_count), 32'd1);
        tick();
        check("grp3_drained", 32'(bus.fifo_count), 32'd0);

        // More encodings across all legal groups
        for (int i = 0; i < 4; i++) begin
            send(tbl_op[i], tbl_s1[i], tbl_s2[i], tbl_rd[i]);
            check("table_instr", bus.instr, tbl_w[i]);
        end
        tick();
        check("table_drained", 32'(bus.out_valid), 32'd0);

        // Fill to full with the consumer stalled
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(5'(k), 5'd1, 5'd2, 5'd3);
        end
        check("full_count", 32'(bus.fifo_count), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_head", bus.instr, exp_q[0]);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = 5'd4;
        tick();
        check("fifth_held_count", 32'(bus.fifo_count), 32'd4);
        check("stall_head_stable", bus.instr, exp_q[0]);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_word", bus.instr, exp_q[i]);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        check("drain_count", 32'(bus.fifo_count), 32'd0);
        check("drain_valid_end", 32'(bus.out_valid), 32'd0);

        // Illegal ops are counted, not queued
        send(5'b11110, 5'd1, 5'd2, 5'd3);
        check("illegal_pulse", 32'(bus.illegal), 32'd1);
        check("illegal_not_queued", 32'(bus.out_valid), 32'd0);
        check("illegal_count1", 32'(bus.err_count), 32'd1);
        tick();
        check("illegal_pulse_end", 32'(bus.illegal), 32'd0);
        send(5'b01000, 5'd0, 5'd0, 5'd0);
        check("illegal_01xxx", 32'(bus.err_count), 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = 5'b10001;
        repeat (254) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("illegal_256", 32'(bus.err_count), 32'd255);
        check("illegal_fifo_empty", 32'(bus.fifo_count), 32'd0);
        send(5'b11110, 5'd0, 5'd0, 5'd0);
        check("illegal_saturate", 32'(bus.err_count), 32'd255);

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(5'(k), 5'd1, 5'd2, 5'd3);
        end
        check("pre_reset_count", 32'(bus.fifo_count), 32'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_count", 32'(bus.fifo_count), 32'd0);
        check("async_rst_err", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease_in_ready", 32'(bus.in_ready), 32'd1);
        send(5'b10000, 5'd5, 5'd6, 5'd7);
        check("after_rst_count", 32'(bus.fifo_count), 32'd1);
        check("after_rst_instr", bus.instr, 32'h406283B3);
        bus.out_ready = 1'b1;
        tick();
        check("after_rst_alone", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rtype_instr_encoder.md
RTYPE_INSTR_ENCODER -- requirements
Module: rtype_instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of output FIFO entries (power of two, 2 to 16).
REQ-002 Parameter ERR_W, default 8, SHALL be the width of the illegal-op counter.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RESET  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 IN_VALID  in  1  SHALL indicate that an encode request is present.
REQ-006 IN_READY  out  1  SHALL indicate that the block can accept a request this cycle.
REQ-007 ALU_OP  in  5  SHALL carry the ALU operation code to encode.
REQ-008 RS1, RS2, RD  in  5 each  SHALL carry the register indices.
REQ-009 OUT_VALID  out  1  SHALL indicate that INSTR holds a valid encoded word.
REQ-010 OUT_READY  in  1  SHALL indicate that the consumer takes INSTR this cycle.
REQ-011 INSTR  out  32  SHALL carry the encoded RV32 R-type instruction at the FIFO head.
REQ-012 ILLEGAL  out  1  SHALL pulse when an unencodable ALU_OP has been consumed.
REQ-013 ERR_COUNT  out  ERR_W  SHALL count the illegal requests consumed.
REQ-014 FIFO_COUNT  out  log2(DEPTH)+1  SHALL report the FIFO occupancy.

Function
REQ-015 A request SHALL be accepted only on a rising edge where IN_VALID and IN_READY are both high.
REQ-016 IN_READY SHALL equal (FIFO_COUNT < DEPTH) and SHALL NOT depend combinationally on OUT_READY.
REQ-017 ALU_OP 00000-00111 SHALL encode as FUN7=0000000 and FUN3=ALU_OP[2:0].
REQ-018 ALU_OP 10000 (SUB) SHALL encode as FUN7=0100000, FUN3=000; ALU_OP 10101 (SRA) SHALL encode as FUN7=0100000, FUN3=101.
REQ-019 ALU_OP 11000-11101 and 11111 SHALL encode as FUN7=0111011 and FUN3=ALU_OP[2:0].
REQ-020 Every other ALU_OP value (including 11110) SHALL be treated as illegal.
REQ-021 The encoded word SHALL be {FUN7, RS2, RS1, FUN3, RD, 7'b0110011}.
REQ-022 An accepted legal request SHALL be written to the FIFO tail at the accepting edge; OUT_VALID SHALL be high in the following cycle (latency 1).
REQ-023 An accepted illegal request SHALL be consumed without being enqueued.
REQ-024 On an accepted illegal request, ILLEGAL SHALL be high for exactly the cycle after the accepting edge, and ERR_COUNT SHALL increment, saturating at 2^ERR_W-1.
REQ-025 OUT_VALID SHALL equal (FIFO_COUNT != 0); the FIFO head SHALL be popped on an edge where OUT_VALID and OUT_READY are both high.
REQ-026 INSTR SHALL hold stable while OUT_VALID=1 and OUT_READY=0, and SHALL read 32'h0 when the FIFO is empty.
REQ-027 A simultaneous legal push and pop SHALL leave FIFO_COUNT unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-028 When full, no push SHALL occur (IN_READY=0); a pop while full SHALL raise IN_READY in the next cycle.
REQ-029 A pop on an empty FIFO SHALL have no effect; words SHALL emerge in acceptance order.

Reset
REQ-030 While RESET=0: FIFO_COUNT=0, pointers=0, OUT_VALID=0, INSTR=0, ILLEGAL=0, ERR_COUNT=0, IN_READY=0, all applied asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO contents; the first edge after RESET rises SHALL see IN_READY=1.

Verification
REQ-032 ALU_OP=00000, RS1=1, RS2=2, RD=3 accepted, OUT_READY=1 -> next cycle OUT_VALID=1, INSTR=0x002081B3.
REQ-033 ALU_OP=10000, RS1=5, RS2=6, RD=7 -> INSTR=0x406283B3; ALU_OP=11000, RS1=1, RS2=2, RD=3 -> INSTR=0x762081B3.
REQ-034 OUT_READY=0, five back-to-back legal requests -> four accepted, FIFO_COUNT=4, IN_READY=0, 5th held; then OUT_READY=1 -> five words drain in order, FIFO_COUNT returns to 0.
REQ-035 ALU_OP=11110 accepted -> OUT_VALID stays 0, ILLEGAL high one cycle, ERR_COUNT=1; 256 illegal requests -> ERR_COUNT=255.
REQ-036 FIFO_COUNT=3, RESET driven low between edges -> OUT_VALID=0 and FIFO_COUNT=0 immediately; after release, the first new request emerges alone.
